// File: rtl/sms4_pkg.sv
// -----------------------------------------------------------------------------
// sms4_pkg
// Shared constants and helpers for the SMS4 key schedule:
//   - ROUNDS, data width, FK system parameters
//   - ck_word(): CK_i constant, byte j = ((4i+j)*7) mod 256, j=0 is the MSB
//   - rotl32()/l_prime(): the key-schedule linear transform L'
//   - state_t: key-expansion controller states
// -----------------------------------------------------------------------------
package sms4_pkg;

    localparam int ROUNDS = 32;
    localparam int DATA_W = 32;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    localparam int ROT_A = 13;
    localparam int ROT_B = 23;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    // 4i+j is at most 127, so the index byte is exact; the *7 product is
    // truncated to 8 bits, which is the mod 256.
    function automatic logic [31:0] ck_word(input logic [4:0] i);
        logic [31:0] ck;
        logic [7:0]  n;
        ck = '0;
        for (int j = 0; j < 4; j++) begin
            n = {1'b0, i, 2'(j)};
            ck[8*(3-j) +: 8] = 8'(n * 8'd7);
        end
        return ck;
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] l_prime(input logic [31:0] b);
        return b ^ rotl32(b, ROT_A) ^ rotl32(b, ROT_B);
    endfunction

endpackage

// File: rtl/sms4_sbox.sv
// -----------------------------------------------------------------------------
// sms4_sbox
// 8-bit combinational SMS4 S-box.
// Ports:
//   data  : input byte
//   subst : substituted byte
// -----------------------------------------------------------------------------
module sms4_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    assign subst = SBOX[data];

endmodule

// File: rtl/sms4_key_expand.sv
// -----------------------------------------------------------------------------
// sms4_key_expand
// Sequential SMS4 key schedule: accepts a 128-bit master key, computes one
// round key per clock into a 32-entry register file, and serves round keys
// through a registered indexed read port in encrypt or decrypt order.
//
// Optional build macro: SMS4_KEY_ZEROIZE_EN adds a synchronous zeroize input
// that wipes keys and state and forces IDLE.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   zeroize      : (SMS4_KEY_ZEROIZE_EN only) wipe pulse
//   key_in       : master key, MK0 in key_in[127:96]
//   key_valid    : key offer; accepted when key_ready is high
//   key_ready    : high in IDLE and READY
//   busy         : high while expanding (32 cycles)
//   keys_valid   : full round-key set available
//   rk_req       : round-key read request
//   rk_dec       : 0 = rk_idx order, 1 = reversed (31 - rk_idx)
//   rk_idx       : round index
//   rk_out       : round key, one cycle after rk_req
//   rk_valid     : rk_out answers a request made while keys_valid was high
// -----------------------------------------------------------------------------
module sms4_key_expand
    import sms4_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
`ifdef SMS4_KEY_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic         rk_req,
    input  logic         rk_dec,
    input  logic [4:0]   rk_idx,
    output logic [31:0]  rk_out,
    output logic         rk_valid
);

    localparam logic [4:0] LAST = 5'(ROUNDS - 1);

    state_t                    state, state_nxt;
    logic                      zero_req;
    logic                      accept;
    logic [DATA_W-1:0]         k0, k1, k2, k3;
    logic [4:0]                round_idx;
    logic [DATA_W-1:0]         ck_cur;
    logic [DATA_W-1:0]         t_in;
    logic [DATA_W-1:0]         tau_out;
    logic [DATA_W-1:0]         rk_new;
    logic [DATA_W-1:0]         rk_mem [ROUNDS];
    logic [4:0]                rd_addr_p0;
    logic                      rd_hit_p0;

`ifdef SMS4_KEY_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        key_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) state_nxt = EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                if (round_idx == LAST) state_nxt = READY;
            end
            READY: begin
                key_ready = 1'b1;
                if (key_valid) state_nxt = EXPAND;
            end
            default: state_nxt = IDLE;
        endcase
        if (zero_req) state_nxt = IDLE;
    end

    // Zeroize outranks a simultaneous key offer.
    assign accept = key_valid && key_ready && !zero_req;

    // ---------------- round function ----------------
    assign ck_cur = ck_word(round_idx);
    assign t_in   = k1 ^ k2 ^ k3 ^ ck_cur;

    for (genvar b = 0; b < 4; b++) begin : g_tau
        sms4_sbox u_sbox (
            .data  (t_in[8*b +: 8]),
            .subst (tau_out[8*b +: 8])
        );
    end

    assign rk_new = k0 ^ l_prime(tau_out);

    // ---------------- key state / round counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k0 <= '0; k1 <= '0; k2 <= '0; k3 <= '0;
            round_idx  <= '0;
            keys_valid <= 1'b0;
        end else if (zero_req) begin
            k0 <= '0; k1 <= '0; k2 <= '0; k3 <= '0;
            round_idx  <= '0;
            keys_valid <= 1'b0;
        end else if (accept) begin
            k0 <= key_in[127:96] ^ FK0;
            k1 <= key_in[95:64]  ^ FK1;
            k2 <= key_in[63:32]  ^ FK2;
            k3 <= key_in[31:0]   ^ FK3;
            round_idx  <= '0;
            keys_valid <= 1'b0;
        end else if (busy) begin
            k0 <= k1;
            k1 <= k2;
            k2 <= k3;
            k3 <= rk_new;
            round_idx <= round_idx + 5'd1;
            if (round_idx == LAST) keys_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < ROUNDS; n++) rk_mem[n] <= '0;
        end else if (zero_req) begin
            for (int n = 0; n < ROUNDS; n++) rk_mem[n] <= '0;
        end else if (busy) begin
            rk_mem[round_idx] <= rk_new;
        end
    end

    // ---------------- read port, stage p0 -> output register ----------------
    // keys_valid is sampled at the request edge, so a read on the edge that
    // accepts a new key still returns the old, fully valid schedule.
    assign rd_addr_p0 = rk_dec ? (LAST - rk_idx) : rk_idx;
    assign rd_hit_p0  = rk_req && keys_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_out   <= '0;
            rk_valid <= 1'b0;
        end else if (zero_req) begin
            rk_out   <= '0;
            rk_valid <= 1'b0;
        end else begin
            rk_valid <= rd_hit_p0;
            if (rd_hit_p0) rk_out <= rk_mem[rd_addr_p0];
        end
    end

endmodule

// File: tb/tb_sms4_key_expand.sv
module tb_sms4_key_expand;

    localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] ALT_KEY = 128'hDEADBEEF_00112233_44556677_8899AABB;
    localparam logic [31:0]  RK0     = 32'hF12186F9;
    localparam logic [31:0]  RK1     = 32'h41662B61;
    localparam logic [31:0]  RK31    = 32'h9124A012;

    typedef struct packed {
        logic [31:0] rk;
        logic        vld;
    } exp_t;

    logic         clk;
    logic         rst_n;
`ifdef SMS4_KEY_ZEROIZE_EN
    logic         zeroize;
`endif
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic         rk_req;
    logic         rk_dec;
    logic [4:0]   rk_idx;
    logic [31:0]  rk_out;
    logic         rk_valid;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    sms4_key_expand dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SMS4_KEY_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_req     (rk_req),
        .rk_dec     (rk_dec),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .rk_valid   (rk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        rst_n = 1'b0; key_valid = 1'b0; key_in = '0;
        rk_req = 1'b0; rk_dec = 1'b0; rk_idx = '0;
`ifdef SMS4_KEY_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        repeat (2) tick();
        n_vec++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL rst_key_ready: got %b want 1", key_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL rst_keys_valid: got %b want 0", keys_valid); end
        n_vec++; if (rk_valid !== 1'b0) begin n_err++; $display("FAIL rst_rk_valid: got %b want 0", rk_valid); end
        n_vec++; if (rk_out !== 32'h0) begin n_err++; $display("FAIL rst_rk_out: got %h want 0", rk_out); end
        rst_n = 1'b1;
        tick();
        // request before any key: no rk_valid, rk_out holds
        rk_req = 1'b1; rk_idx = 5'd3;
        sb_q.push_back('{rk: 32'h0, vld: 1'b0});
        tick();
        rk_req = 1'b0;
        e = sb_q.pop_front();
        n_vec++; if (rk_valid !== e.vld) begin n_err++; $display("FAIL early_rd_valid: got %b want %b", rk_valid, e.vld); end
        n_vec++; if (rk_out !== e.rk) begin n_err++; $display("FAIL early_rd_out: got %h want %h", rk_out, e.rk); end
    endtask

    task automatic test_standard;
        exp_t        e;
        int          cyc, busy_cyc;
        logic [31:0] ck_at31;
        logic [4:0]  idx_l [3];
        logic [31:0] exp_l [3];
        idx_l[0] = 5'd0; idx_l[1] = 5'd1; idx_l[2] = 5'd31;
        exp_l[0] = RK0;  exp_l[1] = RK1;  exp_l[2] = RK31;
        n_vec++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL std_key_ready: got %b want 1", key_ready); end
        key_in = STD_KEY; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        n_vec++; if (dut.ck_cur !== 32'h00070E15) begin n_err++; $display("FAIL ck_i0: got %h want 00070E15", dut.ck_cur); end
        cyc = 0; busy_cyc = 0; ck_at31 = 'x;
        while (keys_valid !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cyc++;
            if (busy === 1'b1 && dut.round_idx == 5'd31) ck_at31 = dut.ck_cur;
            tick();
            cyc++;
        end
        n_vec++; if (ck_at31 !== 32'h646B7279) begin n_err++; $display("FAIL ck_i31: got %h want 646B7279", ck_at31); end
        n_vec++; if (cyc != 32) begin n_err++; $display("FAIL std_latency: got %0d want 32", cyc); end
        n_vec++; if (busy_cyc != 32) begin n_err++; $display("FAIL std_busy_cycles: got %0d want 32", busy_cyc); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL std_busy_done: got %b want 0", busy); end
        for (int n = 0; n < 3; n++) begin
            rk_req = 1'b1; rk_dec = 1'b0; rk_idx = idx_l[n];
            sb_q.push_back('{rk: exp_l[n], vld: 1'b1});
            tick();
            e = sb_q.pop_front();
            n_vec++; if (rk_valid !== e.vld) begin n_err++; $display("FAIL std_rd%0d_valid: got %b want %b", n, rk_valid, e.vld); end
            n_vec++; if (rk_out !== e.rk) begin n_err++; $display("FAIL std_rd%0d_out: got %h want %h", n, rk_out, e.rk); end
        end
        rk_req = 1'b0;
        tick();
    endtask

    task automatic test_decrypt;
        exp_t        e;
        logic [4:0]  idx_l [3];
        logic [31:0] exp_l [3];
        idx_l[0] = 5'd0; idx_l[1] = 5'd31; idx_l[2] = 5'd30;
        exp_l[0] = RK31; exp_l[1] = RK0;   exp_l[2] = RK1;
        for (int n = 0; n < 3; n++) begin
            rk_req = 1'b1; rk_dec = 1'b1; rk_idx = idx_l[n];
            sb_q.push_back('{rk: exp_l[n], vld: 1'b1});
            tick();
            e = sb_q.pop_front();
            n_vec++; if (rk_valid !== e.vld) begin n_err++; $display("FAIL dec_rd%0d_valid: got %b want %b", n, rk_valid, e.vld); end
            n_vec++; if (rk_out !== e.rk) begin n_err++; $display("FAIL dec_rd%0d_out: got %h want %h", n, rk_out, e.rk); end
        end
        rk_req = 1'b0; rk_dec = 1'b0;
        tick();
    endtask

    // New key in READY with a read on the acceptance edge, then a foreign
    // key offered while busy that must be ignored.
    task automatic test_busy_offer;
        exp_t e;
        int   cyc;
        rk_req = 1'b1; rk_dec = 1'b0; rk_idx = 5'd0;
        key_in = STD_KEY; key_valid = 1'b1;
        sb_q.push_back('{rk: RK0, vld: 1'b1});
        tick();
        key_valid = 1'b0;
        e = sb_q.pop_front();
        n_vec++; if (rk_valid !== e.vld) begin n_err++; $display("FAIL acc_edge_rd_valid: got %b want %b", rk_valid, e.vld); end
        n_vec++; if (rk_out !== e.rk) begin n_err++; $display("FAIL acc_edge_rd_out: got %h want %h", rk_out, e.rk); end
        n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL keys_valid_drop: got %b want 0", keys_valid); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reexpand_busy: got %b want 1", busy); end
        cyc = 0;
        rk_idx = 5'd31;
        sb_q.push_back('{rk: RK0, vld: 1'b0});
        tick();
        cyc++;
        rk_req = 1'b0;
        e = sb_q.pop_front();
        n_vec++; if (rk_valid !== e.vld) begin n_err++; $display("FAIL busy_rd_valid: got %b want %b", rk_valid, e.vld); end
        n_vec++; if (rk_out !== e.rk) begin n_err++; $display("FAIL busy_rd_hold: got %h want %h", rk_out, e.rk); end
        while (cyc < 10) begin tick(); cyc++; end
        n_vec++; if (key_ready !== 1'b0) begin n_err++; $display("FAIL busy_key_ready: got %b want 0", key_ready); end
        key_in = ALT_KEY; key_valid = 1'b1;
        tick(); cyc++;
        key_valid = 1'b0;
        while (keys_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        n_vec++; if (cyc != 32) begin n_err++; $display("FAIL busy_offer_latency: got %0d want 32", cyc); end
        rk_req = 1'b1; rk_dec = 1'b0; rk_idx = 5'd31;
        sb_q.push_back('{rk: RK31, vld: 1'b1});
        tick();
        rk_dec = 1'b1; rk_idx = 5'd30;
        sb_q.push_back('{rk: RK1, vld: 1'b1});
        e = sb_q.pop_front();
        n_vec++; if (rk_out !== e.rk || rk_valid !== e.vld) begin n_err++; $display("FAIL busy_offer_rk31: got %h/%b want %h/%b", rk_out, rk_valid, e.rk, e.vld); end
        tick();
        rk_req = 1'b0; rk_dec = 1'b0;
        e = sb_q.pop_front();
        n_vec++; if (rk_out !== e.rk || rk_valid !== e.vld) begin n_err++; $display("FAIL busy_offer_rk1: got %h/%b want %h/%b", rk_out, rk_valid, e.rk, e.vld); end
        tick();
    endtask

    task automatic test_mid_reset;
        key_in = STD_KEY; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (15) tick();
        rst_n = 1'b0;
        #1;
        n_vec++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_key_ready: got %b want 1", key_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_keys_valid: got %b want 0", keys_valid); end
        n_vec++; if (rk_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_rk_valid: got %b want 0", rk_valid); end
        n_vec++; if (rk_out !== 32'h0) begin n_err++; $display("FAIL mid_rst_rk_out: got %h want 0", rk_out); end
        tick();
        rst_n = 1'b1;
        tick();
        test_standard();
    endtask

`ifdef SMS4_KEY_ZEROIZE_EN
    task automatic test_zeroize;
        exp_t e;
        int   cyc;
        n_vec++; if (keys_valid !== 1'b1) begin n_err++; $display("FAIL zz_pre_keys_valid: got %b want 1", keys_valid); end
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL zz_keys_valid: got %b want 0", keys_valid); end
        n_vec++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL zz_idle: got %b want 1", key_ready); end
        n_vec++; if (rk_out !== 32'h0) begin n_err++; $display("FAIL zz_rk_out: got %h want 0", rk_out); end
        rk_req = 1'b1; rk_dec = 1'b0; rk_idx = 5'd0;
        sb_q.push_back('{rk: 32'h0, vld: 1'b0});
        tick();
        rk_req = 1'b0;
        e = sb_q.pop_front();
        n_vec++; if (rk_valid !== e.vld || rk_out !== e.rk) begin n_err++; $display("FAIL zz_rd: got %h/%b want %h/%b", rk_out, rk_valid, e.rk, e.vld); end
        key_in = STD_KEY; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        cyc = 0;
        while (keys_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        n_vec++; if (cyc != 32) begin n_err++; $display("FAIL zz_latency: got %0d want 32", cyc); end
        rk_req = 1'b1; rk_idx = 5'd0;
        sb_q.push_back('{rk: RK0, vld: 1'b1});
        tick();
        rk_req = 1'b0;
        e = sb_q.pop_front();
        n_vec++; if (rk_valid !== e.vld || rk_out !== e.rk) begin n_err++; $display("FAIL zz_rekey_rk0: got %h/%b want %h/%b", rk_out, rk_valid, e.rk, e.vld); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_standard();
        test_decrypt();
        test_busy_offer();
        test_mid_reset();
`ifdef SMS4_KEY_ZEROIZE_EN
        test_zeroize();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
